// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: conv/feature widths, saturation limits,
// signed max and shift-then-saturate helpers.
package cnn_pkg;

    localparam int CONV_OUT_W = 32;
    localparam int FEAT_W     = 16;

    typedef logic signed [CONV_OUT_W-1:0] conv_t;
    typedef logic signed [FEAT_W-1:0]     feat_t;

    localparam conv_t SAT_MAX = conv_t'((1 << (FEAT_W - 1)) - 1);
    localparam conv_t SAT_MIN = -conv_t'(1 << (FEAT_W - 1));

    function automatic conv_t smax(input conv_t a, input conv_t b);
        return (a > b) ? a : b;
    endfunction

    // Floor division by 2^sh, then clamp into the feature range.
    function automatic feat_t sat_shift(input conv_t x, input int unsigned sh);
        conv_t q;
        q = x >>> sh;
        if (q > SAT_MAX)
            return feat_t'(SAT_MAX);
        else if (q < SAT_MIN)
            return feat_t'(SAT_MIN);
        else
            return feat_t'(q);
    endfunction

endpackage

// File: rtl/maxpool2_requant_if.sv
// Streaming bus between the conv engine, the pooling stage and its consumer.
import cnn_pkg::*;

interface maxpool2_requant_if #(
    parameter int IN_W  = CONV_OUT_W,
    parameter int OUT_W = FEAT_W
);
    logic                    iValid;
    logic signed [IN_W-1:0]  iX;
    logic                    oValid;
    logic signed [OUT_W-1:0] oY;
    logic                    oFrameDone;

    modport master (output iValid, iX, input oValid, oY, oFrameDone);
    modport slave  (input iValid, iX, output oValid, oY, oFrameDone);
endinterface

// File: rtl/maxpool2_linebuf.sv
// Holds the horizontal pair maxima of the previous even row, one per pooled column.
import cnn_pkg::*;

module maxpool2_linebuf #(
    parameter int DEPTH = 14,
    parameter int W     = CONV_OUT_W,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic signed [W-1:0] rdata
);
    logic signed [W-1:0] mem [DEPTH];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool2_requant.sv
// 2x2 stride-2 max pool over the conv output stream, requantized to feature width.
// Optional ReLU before the shift when MAXPOOL2_RELU_EN is defined.
import cnn_pkg::*;

module maxpool2_requant #(
    parameter int IN_W  = CONV_OUT_W,
    parameter int OUT_W = FEAT_W,
    parameter int COLS  = 28,
    parameter int ROWS  = 28,
    parameter int SHIFT = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    maxpool2_requant_if.slave bus
);
    localparam int HCOLS = COLS / 2;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW    = (HCOLS > 1) ? $clog2(HCOLS) : 1;

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic signed [IN_W-1:0] h, pair, lb_rd, m, m_q;
    logic                   col_last, row_last, lb_we, fire;
    logic                   vld_p1, done_p1;
    logic signed [OUT_W-1:0] y_p1;

    assign col_last = (col == CW'(COLS - 1));
    assign row_last = (row == RW'(ROWS - 1));
    assign lb_we    = bus.iValid && col[0] && !row[0];
    assign fire     = bus.iValid && col[0] && row[0];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            col <= '0;
            row <= '0;
        end else if (bus.iValid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            h <= '0;
        else if (bus.iValid && !col[0])
            h <= bus.iX;
    end

    assign pair = smax(h, bus.iX);

    maxpool2_linebuf #(.DEPTH(HCOLS), .W(IN_W), .AW(AW)) u_linebuf (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .we    (lb_we),
        .waddr (AW'(col >> 1)),
        .wdata (pair),
        .raddr (AW'(col >> 1)),
        .rdata (lb_rd)
    );

    assign m = smax(lb_rd, pair);

`ifdef MAXPOOL2_RELU_EN
    assign m_q = m[IN_W-1] ? '0 : m;
`else
    assign m_q = m;
`endif

    // Stage p1: registered pooled output, zero whenever no window completes
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            y_p1    <= '0;
        end else begin
            vld_p1  <= fire;
            done_p1 <= fire && row_last && col_last;
            y_p1    <= fire ? sat_shift(m_q, SHIFT) : '0;
        end
    end

    assign bus.oValid     = vld_p1;
    assign bus.oY         = y_p1;
    assign bus.oFrameDone = done_p1;
endmodule

// File: tb/tb_maxpool2_requant.sv
// Directed bench for maxpool2_requant: SHIFT=0 and SHIFT=8 instances share one stimulus stream.
module tb_maxpool2_requant;
    import cnn_pkg::*;

`ifdef MAXPOOL2_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   nvld = 0;
    int   ndone = 0;
    int   sel = 0;

    maxpool2_requant_if #(.IN_W(32), .OUT_W(16)) if0 ();
    maxpool2_requant_if #(.IN_W(32), .OUT_W(16)) if8 ();

    maxpool2_requant #(.SHIFT(0)) dut0 (.iCLK(clk), .iRST(rst), .bus(if0));
    maxpool2_requant #(.SHIFT(8)) dut8 (.iCLK(clk), .iRST(rst), .bus(if8));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int x, input bit ev, input int ey, input bit ed);
        longint ov, oy, od;
        if0.iValid = v; if0.iX = x;
        if8.iValid = v; if8.iX = x;
        @(posedge clk); #1;
        if (sel == 0) begin
            ov = if0.oValid; oy = if0.oY; od = if0.oFrameDone;
        end else begin
            ov = if8.oValid; oy = if8.oY; od = if8.oFrameDone;
        end
        check("oValid", ov, ev);
        check("oY", oy, ev ? ey : 0);
        check("oFrameDone", od, ed);
        if (ov == 1) nvld++;
        if (od == 1) ndone++;
    endtask

    function automatic int in_val(input int kind, input int r, input int c);
        case (kind)
            0: return r * 28 + c;
            1: return 2147483647;
            2: return -2147483647;
            3: case ({r[0], c[0]})
                   2'b00: return -5;
                   2'b01: return -3;
                   2'b10: return -9;
                   default: return -7;
               endcase
            default: case ({r[0], c[0]})
                   2'b00: return 7;
                   2'b01: return -20;
                   2'b10: return 3;
                   default: return -1;
               endcase
        endcase
    endfunction

    // Bottom-right sample is the window maximum of the ramp.
    function automatic int exp_val(input int kind, input int r, input int c);
        case (kind)
            0: return r * 28 + c;
            1: return 32767;
            2: return RELU ? 0 : -32768;
            3: return RELU ? 0 : -3;
            default: return 7;
        endcase
    endfunction

    task automatic run_frame(input int kind, input bit gap, input int stop_after);
        int n;
        bit q;
        n = 0;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                if (n == stop_after) return;
                q = r[0] && c[0];
                drive(1'b1, in_val(kind, r, c), q, exp_val(kind, r, c), q && r == 27 && c == 27);
                if (gap) drive(1'b0, 32'h5a5a5a5a, 1'b0, 0, 1'b0);
                n++;
            end
        end
    endtask

    task automatic frame_counts(input string tag, input int nv, input int nd);
        check({tag, "_pulses"}, nvld, nv);
        check({tag, "_done"}, ndone, nd);
        nvld = 0;
        ndone = 0;
    endtask

    initial begin
        if0.iValid = 1'b0; if0.iX = 0;
        if8.iValid = 1'b0; if8.iX = 0;
        #1;
        check("rst_vld0", if0.oValid, 0);
        check("rst_y0", if0.oY, 0);
        check("rst_done8", if8.oFrameDone, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        sel = 0; nvld = 0; ndone = 0;
        run_frame(0, 1'b0, -1);
        frame_counts("ramp", 196, 1);

        sel = 8;
        run_frame(1, 1'b0, -1);
        frame_counts("satpos", 196, 1);
        run_frame(2, 1'b0, -1);
        frame_counts("satneg", 196, 1);

        sel = 0;
        run_frame(3, 1'b0, -1);
        frame_counts("window", 196, 1);
        run_frame(4, 1'b0, -1);
        frame_counts("mixsign", 196, 1);

        run_frame(0, 1'b1, -1);
        frame_counts("gapped", 196, 1);

        run_frame(0, 1'b0, 100);
        frame_counts("partial", 22, 0);
        rst = 1'b1;
        #1;
        check("midrst_vld", if0.oValid, 0);
        check("midrst_y", if0.oY, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midrst_vld_cyc", if0.oValid, 0);
            check("midrst_y_cyc", if0.oY, 0);
        end
        rst = 1'b0;
        run_frame(0, 1'b0, -1);
        frame_counts("after_rst", 196, 1);

        run_frame(1, 1'b0, -1);
        run_frame(0, 1'b0, -1);
        frame_counts("b2b", 392, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
